// File: rtl/lampada_pkg.sv
// ============================================================================
// lampada_pkg : lamp-mode state encoding and small helpers for controle_lampada
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lampada_pkg;

    typedef enum logic [1:0] {
        AUTO_OFF   = 2'd0,
        AUTO_ON    = 2'd1,
        MANUAL_OFF = 2'd2,
        MANUAL_ON  = 2'd3
    } estado_t;

    function automatic logic is_manual(estado_t e);
        return (e == MANUAL_OFF) || (e == MANUAL_ON);
    endfunction

    function automatic logic is_on(estado_t e);
        return (e == AUTO_ON) || (e == MANUAL_ON);
    endfunction

    // A MAX of 1 still needs a one-bit counter.
    function automatic int cnt_width(int max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/controle_lampada_contador_ms.sv
// ============================================================================
// contador_ms : loadable down-counter that saturates at zero
// Revision    : 1.0
// ============================================================================
`default_nettype none

module contador_ms
    import lampada_pkg::*;
#(
    parameter int MAX = 10,
    localparam int W  = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/controle_lampada.sv
// ============================================================================
// controle_lampada : AUTO/MANUAL lamp controller driven by button events and PIR
// Optional macro CONTROLE_LAMPADA_MANUAL_TIMEOUT_EN adds forced MANUAL->AUTO revert.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module controle_lampada
    import lampada_pkg::*;
#(
    parameter int AUTO_SHUTDOWN_T = 30000,
    parameter int MANUAL_REVERT_T = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic infravermelho,
    output logic led,
    output logic saida
);

    localparam int             TW         = cnt_width(AUTO_SHUTDOWN_T);
    localparam logic [TW-1:0]  TMR_RELOAD = TW'(AUTO_SHUTDOWN_T - 1);

    estado_t       estado;
    estado_t       estado_prox;
    logic          pir_meta;
    logic          pres;
    logic          sair_manual;
    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_zero;
    logic [TW-1:0] tmr_cnt;
    logic          idle_zero;

    contador_ms #(.MAX(AUTO_SHUTDOWN_T)) u_tmr (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .en   (tmr_en),
        .val  (TMR_RELOAD),
        .cnt  (tmr_cnt),
        .zero (tmr_zero)
    );

`ifdef CONTROLE_LAMPADA_MANUAL_TIMEOUT_EN
    localparam int             IW          = cnt_width(MANUAL_REVERT_T);
    localparam logic [IW-1:0]  IDLE_RELOAD = IW'(MANUAL_REVERT_T - 1);

    logic          idle_load;
    logic          idle_en;
    logic [IW-1:0] idle_cnt;

    // Reload on entering MANUAL and on every short press while staying there.
    assign idle_load = is_manual(estado_prox) && (!is_manual(estado) || A);
    assign idle_en   = is_manual(estado);

    contador_ms #(.MAX(MANUAL_REVERT_T)) u_idle (
        .clk  (clk),
        .rst  (rst),
        .load (idle_load),
        .en   (idle_en),
        .val  (IDLE_RELOAD),
        .cnt  (idle_cnt),
        .zero (idle_zero)
    );
`else
    assign idle_zero = 1'b0;
`endif

    assign tmr_en = (estado == AUTO_ON);

    always_comb begin
        estado_prox = estado;
        tmr_load    = 1'b0;
        sair_manual = 1'b0;
        case (estado)
            AUTO_OFF: begin
                if (B) begin
                    estado_prox = MANUAL_OFF;
                end else if (pres) begin
                    estado_prox = AUTO_ON;
                    tmr_load    = 1'b1;
                end
            end
            AUTO_ON: begin
                if (B) begin
                    estado_prox = MANUAL_ON;
                end else if (pres) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    estado_prox = AUTO_OFF;
                end
            end
            MANUAL_OFF: begin
                if (B)      sair_manual = 1'b1;
                else if (A) estado_prox = MANUAL_ON;
            end
            MANUAL_ON: begin
                if (B)      sair_manual = 1'b1;
                else if (A) estado_prox = MANUAL_OFF;
            end
            default: estado_prox = AUTO_OFF;
        endcase

        if (is_manual(estado) && !A && !B && idle_zero) begin
            sair_manual = 1'b1;
        end

        // Returning to AUTO re-evaluates presence in the same cycle.
        if (sair_manual) begin
            estado_prox = pres ? AUTO_ON : AUTO_OFF;
            tmr_load    = pres;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            estado   <= AUTO_OFF;
            led      <= 1'b0;
            saida    <= 1'b0;
            pir_meta <= 1'b0;
            pres     <= 1'b0;
        end else begin
            estado   <= estado_prox;
            led      <= is_manual(estado_prox);
            saida    <= is_on(estado_prox);
            pir_meta <= infravermelho;
            pres     <= pir_meta;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controle_lampada.sv
// ============================================================================
// tb_controle_lampada : scoreboard bench for controle_lampada (T=10, revert=20)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_controle_lampada;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic A = 1'b0;
    logic B = 1'b0;
    logic infravermelho = 1'b0;
    logic led;
    logic saida;

    typedef struct {
        string tag;
        logic  s;
        logic  l;
    } esperado_t;

    esperado_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    controle_lampada #(.AUTO_SHUTDOWN_T(10), .MANUAL_REVERT_T(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .A             (A),
        .B             (B),
        .infravermelho (infravermelho),
        .led           (led),
        .saida         (saida)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {saida,led}=%b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what must appear after the next edge.
    task automatic step(input logic r, input logic a, input logic b, input logic ir,
                        input logic es, input logic el, input string tag);
        esperado_t e;
        @(negedge clk);
        rst = r; A = a; B = b; infravermelho = ir;
        e.tag = tag; e.s = es; e.l = el;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, {saida, led}, {e.s, e.l});
    endtask

    initial begin
        // Reset with every input asserted
        step(0, 1, 1, 1, 0, 0, "rst0");
        step(0, 1, 1, 1, 0, 0, "rst1");
        step(1, 0, 0, 0, 0, 0, "rel");
        step(1, 1, 0, 0, 0, 0, "a_ign");
        step(1, 0, 1, 0, 0, 1, "b_man");
        step(1, 0, 1, 0, 0, 0, "b_auto");

        // Single PIR pulse: on 3 edges later, 10 cycles after last pres
        for (int i = 1; i <= 14; i++)
            step(1, 0, 0, i == 1, (i >= 3) && (i <= 12), 0, $sformatf("pir_%0d", i));

        // Retrigger at step 7 -> pres seen at 9, off at 19
        for (int i = 1; i <= 22; i++)
            step(1, 0, 0, (i == 1) || (i == 7), (i >= 3) && (i <= 18), 0,
                 $sformatf("retrig_%0d", i));

        // AUTO_ON -> MANUAL_ON keeps the lamp; A toggles; PIR ignored
        step(1, 0, 0, 1, 0, 0, "m_s1");
        step(1, 0, 0, 0, 0, 0, "m_s2");
        step(1, 0, 0, 0, 1, 0, "m_on");
        step(1, 0, 1, 0, 1, 1, "m_b");
        step(1, 1, 0, 1, 0, 1, "m_a1");
        step(1, 0, 0, 0, 0, 1, "m_hold");
        step(1, 1, 0, 0, 1, 1, "m_a2");
        step(1, 0, 0, 1, 1, 1, "m_pir1");
        step(1, 0, 0, 0, 1, 1, "m_pir0");

        // A+B together in MANUAL_OFF with presence -> AUTO_ON, no toggle
        step(1, 1, 0, 1, 0, 1, "ab_a");
        step(1, 0, 0, 1, 0, 1, "ab_p1");
        step(1, 0, 0, 1, 0, 1, "ab_p2");
        step(1, 1, 1, 1, 1, 0, "ab_both");

        // Reset mid-operation
        step(0, 0, 0, 1, 0, 0, "mid_rst");
        step(0, 0, 0, 0, 0, 0, "mid_rst2");
        step(1, 0, 0, 0, 0, 0, "mid_rel");
        step(1, 0, 0, 0, 0, 0, "idle");

        // MANUAL idle behaviour
        step(1, 0, 1, 0, 0, 1, "to_man");
`ifdef CONTROLE_LAMPADA_MANUAL_TIMEOUT_EN
        for (int i = 1; i <= 20; i++)
            step(1, 0, 0, 0, 0, i < 20, $sformatf("revert_%0d", i));
        step(1, 0, 0, 0, 0, 0, "after_revert");
`else
        for (int i = 1; i <= 1000; i++)
            step(1, 0, 0, 0, 0, 1, $sformatf("persist_%0d", i));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
